// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - store intake and memory drain bus of the store buffer
interface store_buffer_if;
  logic        st_valid;
  logic [5:0]  st_alucode;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic        mem_ack;

  modport master (
    output st_valid, st_alucode, st_addr, st_data, mem_ack,
    input  st_ready, mem_req, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  st_valid, st_alucode, st_addr, st_data, mem_ack,
    output st_ready, mem_req, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - formats SB/SH/SW stores, queues them and drains them to data memory
module store_buffer #(
  parameter int          DEPTH   = 4,
  parameter int          PTR_W   = 2,
  parameter logic [5:0]  ALU_SB  = 6'h20,
  parameter logic [5:0]  ALU_SH  = 6'h21,
  parameter logic [5:0]  ALU_SW  = 6'h22,
  parameter logic [31:0] HC_ADDR = 32'hffff_ff00
) (
  input  logic             clk,
  input  logic             rstd,
  store_buffer_if.slave    bus,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  output logic             ld_hazard,
  output logic             hc_clr,
  output logic             misalign,
  output logic [PTR_W:0]   count,
  output logic             empty
);
  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       we_q   [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rel;
  logic [1:0]       off;
  logic [3:0]       we_fmt;
  logic [31:0]      wdata_fmt;
  logic             legal_op, aligned, is_hc, accept, push, pop, match;

  assign off = bus.st_addr[1:0];

  always_comb begin
    legal_op  = 1'b1;
    aligned   = 1'b1;
    we_fmt    = 4'b0000;
    wdata_fmt = bus.st_data;
    case (bus.st_alucode)
      ALU_SB: begin
        we_fmt    = 4'b0001 << off;
        wdata_fmt = {4{bus.st_data[7:0]}};
      end
      ALU_SH: begin
        aligned   = ~off[0];
        we_fmt    = off[1] ? 4'b1100 : 4'b0011;
        wdata_fmt = {2{bus.st_data[15:0]}};
      end
      ALU_SW: begin
        aligned = (off == 2'b00);
        we_fmt  = 4'b1111;
      end
      default: legal_op = 1'b0;
    endcase
  end

  assign is_hc  = (bus.st_addr == HC_ADDR);
  assign accept = bus.st_valid & (count != (PTR_W+1)'(DEPTH)) & legal_op;
  // Misaligned and counter-address stores are consumed here and never reach memory.
  assign push   = accept & aligned & ~is_hc;
  assign pop    = bus.mem_req & bus.mem_ack;

  assign empty        = (count == '0);
  assign bus.st_ready = (count != (PTR_W+1)'(DEPTH));
  assign bus.mem_req  = ~empty;
  assign bus.mem_addr  = empty ? 32'h0 : {addr_q[rd_ptr], 2'b00};
  assign bus.mem_wdata = empty ? 32'h0 : data_q[rd_ptr];
  assign bus.mem_we    = empty ? 4'h0  : we_q[rd_ptr];

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    rel   = '0;
    match = push & (bus.st_addr[31:2] == ld_addr[31:2]);
    for (int i = 0; i < DEPTH; i++) begin
      rel = PTR_W'(i) - rd_ptr;
      if (({1'b0, rel} < count) && (addr_q[i] == ld_addr[31:2]))
        match = 1'b1;
    end
  end

  assign ld_hazard = ld_valid & match;

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      hc_clr   <= 1'b0;
      misalign <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      misalign <= accept & ~aligned;
      hc_clr   <= accept & aligned & is_hc;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= bus.st_addr[31:2];
      data_q[wr_ptr] <= wdata_fmt;
      we_q[wr_ptr]   <= we_fmt;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - scoreboard bench for store_buffer
module tb_store_buffer;
  localparam logic [5:0]  ALU_SB  = 6'h20;
  localparam logic [5:0]  ALU_SH  = 6'h21;
  localparam logic [5:0]  ALU_SW  = 6'h22;
  localparam logic [31:0] HC_ADDR = 32'hffff_ff00;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  w;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstd = 1'b0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = 32'h0;
  logic        ld_hazard, hc_clr, misalign, empty;
  logic [2:0]  count;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb_q[$];

  store_buffer_if sb_bus();

  store_buffer #(
    .DEPTH(4), .PTR_W(2), .ALU_SB(ALU_SB), .ALU_SH(ALU_SH), .ALU_SW(ALU_SW), .HC_ADDR(HC_ADDR)
  ) dut (
    .clk(clk),
    .rstd(rstd),
    .bus(sb_bus),
    .ld_valid(ld_valid),
    .ld_addr(ld_addr),
    .ld_hazard(ld_hazard),
    .hc_clr(hc_clr),
    .misalign(misalign),
    .count(count),
    .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head is compared against the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rstd && sb_bus.mem_req && sb_bus.mem_ack) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pop: got addr 0x%08h, required no request", sb_bus.mem_addr);
      end else begin
        e = sb_q.pop_front();
        check("mem_addr", sb_bus.mem_addr, e.a);
        check("mem_wdata", sb_bus.mem_wdata, e.d);
        check("mem_we", {28'h0, sb_bus.mem_we}, {28'h0, e.w});
      end
    end
  end

  task automatic do_store(input logic [5:0] code, input logic [31:0] a, input logic [31:0] d,
                          input bit enq, input logic [31:0] ea, input logic [31:0] ed,
                          input logic [3:0] ew);
    bit done;
    done = 1'b0;
    sb_bus.st_valid   = 1'b1;
    sb_bus.st_alucode = code;
    sb_bus.st_addr    = a;
    sb_bus.st_data    = d;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (sb_bus.st_ready) begin
        done = 1'b1;
        if (enq) sb_q.push_back({ea, ed, ew});
      end
      @(posedge clk);
      #1;
    end
    sb_bus.st_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL store_accept_timeout: got st_ready=0 for 20 cycles, required acceptance");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_empty(input string name);
    int i;
    i = 0;
    while (!empty && i < 50) begin
      @(posedge clk);
      #1;
      i++;
    end
    check(name, empty, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    sb_bus.st_valid   = 1'b0;
    sb_bus.st_alucode = 6'h0;
    sb_bus.st_addr    = 32'h0;
    sb_bus.st_data    = 32'h0;
    sb_bus.mem_ack    = 1'b0;
    #12;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_st_ready", sb_bus.st_ready, 1);
    check("rst_mem_req", sb_bus.mem_req, 0);
    check("rst_mem_we", sb_bus.mem_we, 0);
    check("rst_mem_addr", sb_bus.mem_addr, 0);
    check("rst_mem_wdata", sb_bus.mem_wdata, 0);
    check("rst_hc_clr", hc_clr, 0);
    check("rst_misalign", misalign, 0);
    check("rst_ld_hazard", ld_hazard, 0);
    rstd = 1'b1;
    @(posedge clk);
    #1;

    // SB lane sweep, drained as it goes
    sb_bus.mem_ack = 1'b1;
    do_store(ALU_SB, 32'h100, 32'h0000_00A5, 1, 32'h100, 32'hA5A5_A5A5, 4'b0001);
    do_store(ALU_SB, 32'h101, 32'h0000_00A5, 1, 32'h100, 32'hA5A5_A5A5, 4'b0010);
    do_store(ALU_SB, 32'h102, 32'h0000_00A5, 1, 32'h100, 32'hA5A5_A5A5, 4'b0100);
    do_store(ALU_SB, 32'h103, 32'h0000_00A5, 1, 32'h100, 32'hA5A5_A5A5, 4'b1000);
    wait_empty("sb_sweep_drain");

    // Misaligned stores and an illegal opcode
    sb_bus.mem_ack = 1'b0;
    do_store(ALU_SW, 32'h205, 32'h1234_5678, 0, 32'h0, 32'h0, 4'h0);
    check("sw_misalign_pulse", misalign, 1);
    check("sw_misalign_count", count, 0);
    check("sw_misalign_req", sb_bus.mem_req, 0);
    check("sw_misalign_hc", hc_clr, 0);
    do_store(ALU_SH, 32'h201, 32'h0000_BEEF, 0, 32'h0, 32'h0, 4'h0);
    check("sh_misalign_pulse2", misalign, 1);
    idle(1);
    check("misalign_falls", misalign, 0);
    do_store(6'h00, 32'h240, 32'hDEAD_BEEF, 0, 32'h0, 32'h0, 4'h0);
    check("illegal_op_count", count, 0);
    check("illegal_op_misalign", misalign, 0);

    // SH both halves
    sb_bus.mem_ack = 1'b1;
    do_store(ALU_SH, 32'h202, 32'h0000_BEEF, 1, 32'h200, 32'hBEEF_BEEF, 4'b1100);
    do_store(ALU_SH, 32'h200, 32'h1234_CAFE, 1, 32'h200, 32'hCAFE_CAFE, 4'b0011);
    wait_empty("sh_drain");

    // Fill to DEPTH, fifth store held off until one ack
    sb_bus.mem_ack = 1'b0;
    do_store(ALU_SW, 32'h1000, 32'h1111_1111, 1, 32'h1000, 32'h1111_1111, 4'b1111);
    do_store(ALU_SW, 32'h1004, 32'h2222_2222, 1, 32'h1004, 32'h2222_2222, 4'b1111);
    do_store(ALU_SW, 32'h1008, 32'h3333_3333, 1, 32'h1008, 32'h3333_3333, 4'b1111);
    do_store(ALU_SW, 32'h100C, 32'h4444_4444, 1, 32'h100C, 32'h4444_4444, 4'b1111);
    check("full_st_ready", sb_bus.st_ready, 0);
    check("full_count", count, 4);
    fork
      do_store(ALU_SW, 32'h1010, 32'h5555_5555, 1, 32'h1010, 32'h5555_5555, 4'b1111);
      begin
        @(posedge clk);
        #1;
        check("full_holdoff_count", count, 4);
        sb_bus.mem_ack = 1'b1;
        @(posedge clk);
        #1;
        sb_bus.mem_ack = 1'b0;
        check("after_ack_ready", sb_bus.st_ready, 1);
        check("after_ack_count", count, 3);
      end
    join
    check("fifth_in_count", count, 4);
    check("fifth_in_head", sb_bus.mem_addr, 32'h1004);
    sb_bus.mem_ack = 1'b1;
    wait_empty("fill_drain");

    // Push and pop in the same cycle
    sb_bus.mem_ack = 1'b0;
    do_store(ALU_SW, 32'h2000, 32'hA0A0_A0A0, 1, 32'h2000, 32'hA0A0_A0A0, 4'b1111);
    do_store(ALU_SW, 32'h2004, 32'hB0B0_B0B0, 1, 32'h2004, 32'hB0B0_B0B0, 4'b1111);
    check("pp_count_before", count, 2);
    sb_bus.mem_ack = 1'b1;
    do_store(ALU_SW, 32'h2008, 32'hC0C0_C0C0, 1, 32'h2008, 32'hC0C0_C0C0, 4'b1111);
    sb_bus.mem_ack = 1'b0;
    check("pp_count_after", count, 2);
    check("pp_head_addr", sb_bus.mem_addr, 32'h2004);
    check("pp_head_data", sb_bus.mem_wdata, 32'hB0B0_B0B0);
    sb_bus.mem_ack = 1'b1;
    wait_empty("pp_drain");

    // Load hazard
    sb_bus.mem_ack = 1'b0;
    do_store(ALU_SB, 32'h300, 32'h0000_005A, 1, 32'h300, 32'h5A5A_5A5A, 4'b0001);
    ld_valid = 1'b1;
    ld_addr  = 32'h302;
    #1 check("hz_same_word", ld_hazard, 1);
    ld_addr = 32'h304;
    #1 check("hz_next_word", ld_hazard, 0);
    ld_valid = 1'b0;
    ld_addr  = 32'h300;
    #1 check("hz_no_load", ld_hazard, 0);
    sb_bus.mem_ack = 1'b1;
    wait_empty("hz_drain");
    ld_valid = 1'b1;
    ld_addr  = 32'h302;
    #1 check("hz_after_drain", ld_hazard, 0);
    ld_addr           = 32'h400;
    sb_bus.st_valid   = 1'b1;
    sb_bus.st_alucode = ALU_SW;
    sb_bus.st_addr    = 32'h400;
    sb_bus.st_data    = 32'h0BAD_F00D;
    #1 check("hz_incoming_store", ld_hazard, 1);
    do_store(ALU_SW, 32'h400, 32'h0BAD_F00D, 1, 32'h400, 32'h0BAD_F00D, 4'b1111);
    ld_valid = 1'b0;
    wait_empty("hz_incoming_drain");

    // Hardware-counter address
    sb_bus.mem_ack = 1'b0;
    do_store(ALU_SW, HC_ADDR, 32'h0, 0, 32'h0, 32'h0, 4'h0);
    check("hc_pulse", hc_clr, 1);
    check("hc_count", count, 0);
    check("hc_no_misalign", misalign, 0);
    idle(1);
    check("hc_falls", hc_clr, 0);

    // Asynchronous reset with entries pending
    do_store(ALU_SW, 32'h3000, 32'h0000_0001, 1, 32'h3000, 32'h0000_0001, 4'b1111);
    do_store(ALU_SW, 32'h3004, 32'h0000_0002, 1, 32'h3004, 32'h0000_0002, 4'b1111);
    do_store(ALU_SW, 32'h3008, 32'h0000_0003, 1, 32'h3008, 32'h0000_0003, 4'b1111);
    check("pre_reset_count", count, 3);
    #2;
    rstd = 1'b0;
    sb_q.delete();
    #1;
    check("async_rst_mem_req", sb_bus.mem_req, 0);
    check("async_rst_empty", empty, 1);
    check("async_rst_count", count, 0);
    check("async_rst_mem_we", sb_bus.mem_we, 0);
    @(posedge clk);
    #1;
    rstd = 1'b1;
    idle(2);
    check("post_reset_empty", empty, 1);
    check("post_reset_req", sb_bus.mem_req, 0);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
